ex_mem_stage: RTL

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_if.sv | 59 +++++
 rtl/ex_mem_stage.sv | 135 +++++++++++++
 2 files changed

// File: rtl/ex_mem_if.sv
// EX/MEM stage bundle: ID/EX operands and controls, WB forwarding source,
// redirect outputs and the registered EX/MEM outputs.
interface ex_mem_if;
  logic        flush;
  logic        stall;
  logic [31:0] in_A;
  logic [31:0] in_B;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [3:0]  in_control;
  logic [2:0]  in_funct3;
  logic        in_reg_write;
  logic        in_wed;
  logic        in_is_branch_instr;
  logic        in_is_jmp_instr;
  logic        in_is_jmpr_instr;
  logic        in_ALUSrc;
  logic [1:0]  in_Result_Src;
  logic [31:0] in_pc;
  logic [31:0] in_pc_plus_4;
  logic [31:0] in_immediate;
  logic [4:0]  in_rd;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        pc_redirect;
  logic [31:0] redirect_target;
  logic [31:0] o_alu_result;
  logic [31:0] o_write_data;
  logic [31:0] o_pc_plus_4;
  logic [4:0]  o_rd;
  logic        o_reg_write;
  logic        o_wed;
  logic [1:0]  o_Result_Src;

  modport master (
    output flush, stall, in_A, in_B, in_rs1, in_rs2,
    output in_control, in_funct3, in_reg_write, in_wed,
    output in_is_branch_instr, in_is_jmp_instr,
    output in_is_jmpr_instr, in_ALUSrc, in_Result_Src,
    output in_pc, in_pc_plus_4, in_immediate, in_rd,
    output wb_reg_write, wb_rd, wb_data,
    input  pc_redirect, redirect_target,
    input  o_alu_result, o_write_data, o_pc_plus_4,
    input  o_rd, o_reg_write, o_wed, o_Result_Src
  );

  modport slave (
    input  flush, stall, in_A, in_B, in_rs1, in_rs2,
    input  in_control, in_funct3, in_reg_write, in_wed,
    input  in_is_branch_instr, in_is_jmp_instr,
    input  in_is_jmpr_instr, in_ALUSrc, in_Result_Src,
    input  in_pc, in_pc_plus_4, in_immediate, in_rd,
    input  wb_reg_write, wb_rd, wb_data,
    output pc_redirect, redirect_target,
    output o_alu_result, o_write_data, o_pc_plus_4,
    output o_rd, o_reg_write, o_wed, o_Result_Src
  );
endinterface

// File: rtl/ex_mem_stage.sv
// Execute stage with forwarding, ALU, branch resolution and EX/MEM register.
// Ports: clk, rst (async active-low), bus (ex_mem_if.slave).
module ex_mem_stage (
  input logic   clk,
  input logic   rst,
  ex_mem_if.slave bus
);
  logic [31:0] r_alu;
  logic [31:0] r_wd;
  logic [31:0] r_pc4;
  logic [4:0]  r_rd;
  logic        r_rw;
  logic        r_wed;
  logic [1:0]  r_rs;

  logic [31:0] w_exm_val;
  logic        w_exm_ok;
  logic        w_wb_ok;
  logic [31:0] w_fa;
  logic [31:0] w_fb;
  logic [31:0] w_op2;
  logic [4:0]  w_sh;
  logic [31:0] w_alu;
  logic        w_cond;
  logic        w_taken;
  logic        w_redir;
  logic [31:0] w_jr;

  // Loads are never forwarded from EX/MEM; hazard logic stalls instead.
  assign w_exm_val = (r_rs == 2'b10) ? r_pc4 : r_alu;
  assign w_exm_ok  = r_rw && (r_rd != 5'd0) && (r_rs != 2'b01);
  assign w_wb_ok   = bus.wb_reg_write && (bus.wb_rd != 5'd0);

  always_comb begin
    w_fa = bus.in_A;
    if (w_exm_ok && (r_rd == bus.in_rs1))
      w_fa = w_exm_val;
    else if (w_wb_ok && (bus.wb_rd == bus.in_rs1))
      w_fa = bus.wb_data;
  end

  always_comb begin
    w_fb = bus.in_B;
    if (w_exm_ok && (r_rd == bus.in_rs2))
      w_fb = w_exm_val;
    else if (w_wb_ok && (bus.wb_rd == bus.in_rs2))
      w_fb = bus.wb_data;
  end

  assign w_op2 = bus.in_ALUSrc ? bus.in_immediate : w_fb;
  assign w_sh  = w_op2[4:0];

  always_comb begin
    w_alu = w_op2;
    case (bus.in_control)
      4'b0000: w_alu = w_fa + w_op2;
      4'b0001: w_alu = w_fa - w_op2;
      4'b0010: w_alu = w_fa & w_op2;
      4'b0011: w_alu = w_fa | w_op2;
      4'b0100: w_alu = w_fa ^ w_op2;
      4'b0101: w_alu = w_fa << w_sh;
      4'b0110: w_alu = w_fa >> w_sh;
      4'b0111: w_alu = $unsigned($signed(w_fa) >>> w_sh);
      4'b1000: w_alu = {31'd0, $signed(w_fa) < $signed(w_op2)};
      4'b1001: w_alu = {31'd0, w_fa < w_op2};
      default: w_alu = w_op2;
    endcase
  end

  always_comb begin
    w_cond = 1'b0;
    case (bus.in_funct3)
      3'b000:  w_cond = (w_fa == w_fb);
      3'b001:  w_cond = (w_fa != w_fb);
      3'b100:  w_cond = ($signed(w_fa) < $signed(w_fb));
      3'b101:  w_cond = ($signed(w_fa) >= $signed(w_fb));
      3'b110:  w_cond = (w_fa < w_fb);
      3'b111:  w_cond = (w_fa >= w_fb);
      default: w_cond = 1'b0;
    endcase
  end

  assign w_taken = bus.in_is_branch_instr && w_cond;
  assign w_redir = (w_taken || bus.in_is_jmp_instr || bus.in_is_jmpr_instr)
                   && !bus.stall && !bus.flush;
  assign w_jr    = w_fa + bus.in_immediate;

  always_comb begin
    bus.redirect_target = 32'd0;
    if (w_redir) begin
      if (w_taken || bus.in_is_jmp_instr)
        bus.redirect_target = bus.in_pc + bus.in_immediate;
      else
        bus.redirect_target = {w_jr[31:1], 1'b0};
    end
  end

  assign bus.pc_redirect = w_redir;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alu <= '0;
      r_wd  <= '0;
      r_pc4 <= '0;
      r_rd  <= '0;
      r_rw  <= 1'b0;
      r_wed <= 1'b0;
      r_rs  <= '0;
    end else if (bus.flush) begin
      r_alu <= '0;
      r_wd  <= '0;
      r_pc4 <= '0;
      r_rd  <= '0;
      r_rw  <= 1'b0;
      r_wed <= 1'b0;
      r_rs  <= '0;
    end else if (!bus.stall) begin
      r_alu <= w_alu;
      r_wd  <= w_fb;
      r_pc4 <= bus.in_pc_plus_4;
      r_rd  <= bus.in_rd;
      r_rw  <= bus.in_reg_write;
      r_wed <= bus.in_wed;
      r_rs  <= bus.in_Result_Src;
    end
  end

  assign bus.o_alu_result = r_alu;
  assign bus.o_write_data = r_wd;
  assign bus.o_pc_plus_4  = r_pc4;
  assign bus.o_rd         = r_rd;
  assign bus.o_reg_write  = r_rw;
  assign bus.o_wed        = r_wed;
  assign bus.o_Result_Src = r_rs;
endmodule
